controle_ciclo: RTL and testbench

Central cycle controller for the multi-cycle datapath. It counts the fixed-length instruction slot once and issues one-cycle stage-enable strobes to the datapath components, so they no longer each need their own slot counter. It also drives the PC-select control of the PC multiplexer from the branch decision, and handles stall, halt and instruction counting.

---
 rtl/controle_ciclo_if.sv | 32 +++
 rtl/controle_ciclo.sv | 127 ++++++++++++
 tb/tb_controle_ciclo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/controle_ciclo_if.sv
// Control bundle between the cycle controller and the datapath: run-control
// inputs towards the controller, stage strobes and status back out.
interface controle_ciclo_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             stall;
    logic             halt_req;
    logic             branch_taken;
    logic             en_fetch;
    logic             en_decode;
    logic             en_exec;
    logic             en_mem;
    logic             en_wb;
    logic             pc_sel;
    logic [CNT_W-1:0] cont;
    logic             busy;
    logic             done;
    logic [15:0]      instr_count;

    modport master (
        output start, stall, halt_req, branch_taken,
        input  en_fetch, en_decode, en_exec, en_mem, en_wb,
        input  pc_sel, cont, busy, done, instr_count
    );

    modport slave (
        input  start, stall, halt_req, branch_taken,
        output en_fetch, en_decode, en_exec, en_mem, en_wb,
        output pc_sel, cont, busy, done, instr_count
    );
endinterface

// File: rtl/controle_ciclo.sv
// Central cycle controller: counts the instruction slot, issues one-cycle
// stage strobes, drives the PC mux select and handles stall/halt/counting.
module controle_ciclo #(
    parameter int SLOT_LEN   = 10,
    parameter int CNT_W      = 4,
    parameter int POS_FETCH  = 1,
    parameter int POS_DECODE = 3,
    parameter int POS_EXEC   = 5,
    parameter int POS_MEM    = 7,
    parameter int POS_WB     = 8
) (
    input  logic              clock,
    input  logic              reset,
    controle_ciclo_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(SLOT_LEN - 1);
    localparam logic [CNT_W-1:0] P_FET  = CNT_W'(POS_FETCH);
    localparam logic [CNT_W-1:0] P_DEC  = CNT_W'(POS_DECODE);
    localparam logic [CNT_W-1:0] P_EXE  = CNT_W'(POS_EXEC);
    localparam logic [CNT_W-1:0] P_MEM  = CNT_W'(POS_MEM);
    localparam logic [CNT_W-1:0] P_WB   = CNT_W'(POS_WB);

    generate
        if (!((2 ** CNT_W) >= SLOT_LEN && 0 < POS_FETCH && POS_FETCH < POS_DECODE &&
              POS_DECODE < POS_EXEC && POS_EXEC < POS_MEM && POS_MEM <= POS_WB &&
              POS_WB < SLOT_LEN)) begin : g_bad_params
            $error("controle_ciclo: inconsistent slot length or strobe positions");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cont_q, cont_d, cont_inc;
    logic [4:0]       stb_q, stb_d;      // {wb, mem, exec, decode, fetch}
    logic             pc_sel_q, pc_sel_d;
    logic             halt_q, halt_d;
    logic [15:0]      count_q, count_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cont_q   <= '0;
            stb_q    <= '0;
            pc_sel_q <= 1'b0;
            halt_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cont_q   <= cont_d;
            stb_q    <= stb_d;
            pc_sel_q <= pc_sel_d;
            halt_q   <= halt_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cont_d   = cont_q;
        stb_d    = '0;
        pc_sel_d = pc_sel_q;
        halt_d   = halt_q;
        count_d  = count_q;
        cont_inc = cont_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cont_d  = '0;
                end
            end

            RUN: begin
                if (bus.halt_req) begin
                    halt_d = 1'b1;
                end
                // Branch is captured as the en_exec cycle ends, stalled or not.
                if (stb_q[2]) begin
                    pc_sel_d = bus.branch_taken;
                end
                if (!bus.stall) begin
                    if (cont_q == LAST) begin
                        cont_d   = '0;
                        pc_sel_d = 1'b0;
                        if (count_q != '1) begin
                            count_d = count_q + 16'd1;
                        end
                        if (halt_q || bus.halt_req) begin
                            state_d = HALTED;
                            halt_d  = 1'b0;
                        end
                    end else begin
                        cont_d = cont_inc;
                        stb_d  = {cont_inc == P_WB, cont_inc == P_MEM, cont_inc == P_EXE,
                                  cont_inc == P_DEC, cont_inc == P_FET};
                    end
                end
            end

            HALTED: begin
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cont        = cont_q;
    assign bus.en_fetch    = stb_q[0];
    assign bus.en_decode   = stb_q[1];
    assign bus.en_exec     = stb_q[2];
    assign bus.en_mem      = stb_q[3];
    assign bus.en_wb       = stb_q[4];
    assign bus.pc_sel      = pc_sel_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == HALTED);
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_controle_ciclo.sv
// Scoreboard bench for controle_ciclo: a slot-level reference model predicts
// every cycle's outputs, a separate monitor pops and compares them.
module tb_controle_ciclo;

    localparam int SLOT_LEN = 10;
    localparam int CNT_W    = 4;
    localparam int POS_F = 1, POS_D = 3, POS_E = 5, POS_M = 7, POS_W = 8;

    typedef struct packed {
        logic [CNT_W-1:0] cont;
        logic [4:0]       stb;
        logic             pc_sel;
        logic             busy;
        logic             done;
        logic [15:0]      cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    controle_ciclo_if #(.CNT_W(CNT_W)) bus ();

    controle_ciclo #(
        .SLOT_LEN(SLOT_LEN), .CNT_W(CNT_W),
        .POS_FETCH(POS_F), .POS_DECODE(POS_D), .POS_EXEC(POS_E),
        .POS_MEM(POS_M), .POS_WB(POS_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: mode 0 idle, 1 running, 2 halted.
    int   m_mode  = 0;
    int   m_pos   = 0;
    int   m_count = 0;
    bit   m_pc    = 0;
    bit   m_pend  = 0;
    bit   [4:0] m_stb = '0;
    int   positions[5] = '{POS_F, POS_D, POS_E, POS_M, POS_W};

    task automatic model_step(input bit rst, input bit st, input bit sl,
                              input bit hr, input bit br);
        bit was_exec;
        was_exec = m_stb[2];
        m_stb    = '0;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_count = 0; m_pc = 0; m_pend = 0;
        end else if (m_mode == 0) begin
            if (st) begin
                m_mode = 1;
                m_pos  = 0;
            end
        end else if (m_mode == 1) begin
            if (was_exec) m_pc = br;
            if (hr) m_pend = 1;
            if (!sl) begin
                if (m_pos == SLOT_LEN - 1) begin
                    m_count = (m_count < 65535) ? m_count + 1 : 65535;
                    m_pc    = 0;
                    m_pos   = 0;
                    if (m_pend) begin
                        m_mode = 2;
                        m_pend = 0;
                    end
                end else begin
                    m_pos = m_pos + 1;
                    foreach (positions[k]) m_stb[k] = (m_pos == positions[k]);
                end
            end
        end
    endtask

    task automatic drive(input bit rst, input bit st, input bit sl,
                         input bit hr, input bit br);
        exp_t e;
        @(negedge clock);
        reset            = rst;
        bus.start        = st;
        bus.stall        = sl;
        bus.halt_req     = hr;
        bus.branch_taken = br;
        model_step(rst, st, sl, hr, br);
        e.cont   = CNT_W'(m_pos);
        e.stb    = m_stb;
        e.pc_sel = m_pc;
        e.busy   = (m_mode == 1);
        e.done   = (m_mode == 2);
        e.cnt    = 16'(m_count);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cont", int'(bus.cont), int'(e.cont));
                chk("strobes", int'({bus.en_wb, bus.en_mem, bus.en_exec,
                                     bus.en_decode, bus.en_fetch}), int'(e.stb));
                chk("pc_sel", int'(bus.pc_sel), int'(e.pc_sel));
                chk("busy", int'(bus.busy), int'(e.busy));
                chk("done", int'(bus.done), int'(e.done));
                chk("instr_count", int'(bus.instr_count), int'(e.cnt));
            end
        end
    end

    initial begin : stimulus
        int stall_left;
        bus.start = 0; bus.stall = 0; bus.halt_req = 0; bus.branch_taken = 0;

        // Basic slot, branch in slot 1, 3-cycle stall at cont 4, halt at cont 2 of slot 3.
        repeat (2) drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0);
        stall_left = 3;
        for (int i = 0; i < 60; i++) begin
            bit sl;
            sl = (m_count == 1 && m_pos == 4 && stall_left > 0);
            if (sl) stall_left--;
            drive(0, (i > 40), sl, (m_count == 2 && m_pos == 2), (m_count == 0));
        end

        // Halt request exactly on the wrap cycle.
        repeat (2) drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 25; i++)
            drive(0, 0, 0, (m_count == 1 && m_pos == 9), 0);

        // Halt pulse at cont 7, stall over the wrap for 2 cycles.
        repeat (2) drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        stall_left = 2;
        for (int i = 0; i < 20; i++) begin
            bit sl;
            sl = (m_mode == 1 && m_pos == 9 && stall_left > 0);
            if (sl) stall_left--;
            drive(0, 0, sl, (m_mode == 1 && m_pos == 7), 0);
        end

        // Reset mid-slot with pc_sel set and a halt pending, then a fresh run.
        repeat (2) drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 40 && !(m_pos == 6 && m_pc && m_pend); i++)
            drive(0, 0, 0, (m_pos == 2), 1);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0);
        repeat (15) drive(0, 0, 0, 0, $urandom_range(0, 1));

        // Randomized episodes with varying stall and halt density.
        for (int ep = 0; ep < 8; ep++) begin
            int stall_pct;
            stall_pct = 5 + ep * 5;
            repeat (2) drive(1, 0, 0, 0, 0);
            for (int i = 0; i < 250; i++) begin
                drive(($urandom_range(0, 399) == 0),
                      ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 99) < stall_pct),
                      ($urandom_range(0, 119) == 0),
                      $urandom_range(0, 1));
            end
        end

        repeat (3) @(posedge clock);
        #2;
        chk("scoreboard_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
